// File: rtl/coupler_arb.sv
// coupler_arb: shares one coupler input among P_NUM run-based requester FIFOs.
// Define COUPLER_ARB_FIXED_PRIO_EN for fixed priority; default is round-robin.
module coupler_arb #(
  parameter int P_WIDTH = 128,
  parameter int P_NUM   = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [P_NUM*P_WIDTH-1:0]   i_data,
  input  logic [P_NUM-1:0]           i_empty,
  output logic [P_NUM-1:0]           o_deq,
  output logic [P_WIDTH-1:0]         o_data,
  output logic                       o_enq,
  input  logic                       i_full,
  output logic [P_NUM-1:0]           o_grant,
  output logic                       o_busy
);

  localparam int PW = (P_NUM > 2) ? $clog2(P_NUM) : 1;

  typedef logic [PW-1:0] ptr_t;
  typedef enum logic {ST_IDLE, ST_STREAM} state_t;

  state_t             state;
  ptr_t               ptr;
  ptr_t               owner;
  logic               pick_vld;
  ptr_t               pick_idx;
  logic [P_NUM-1:0]   pick_oh;
  logic [P_WIDTH-1:0] sel_data;
  logic               xfer;
  logic               last;
  ptr_t               ptr_nxt;

  // Scan from highest offset down so the nearest candidate wins.
  always_comb begin
    int k;
    k        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = P_NUM - 1; i >= 0; i--) begin
`ifdef COUPLER_ARB_FIXED_PRIO_EN
      k = i;
`else
      k = (int'(ptr) + i) % P_NUM;
`endif
      if (!i_empty[k]) begin
        pick_vld = 1'b1;
        pick_idx = ptr_t'(k);
      end
    end
  end

  always_comb begin
    pick_oh = '0;
    if (pick_vld) pick_oh[pick_idx] = 1'b1;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < P_NUM; i++) begin
      if (o_grant[i]) sel_data = sel_data | i_data[i*P_WIDTH +: P_WIDTH];
    end
  end

  assign o_busy  = (state == ST_STREAM);
  assign o_deq   = (o_busy && i_rst_n)
                 ? (o_grant & ~i_empty & {P_NUM{~i_full}})
                 : '0;
  assign xfer    = |o_deq;
  assign last    = xfer && (sel_data == '0);
  assign ptr_nxt = (owner == ptr_t'(P_NUM - 1)) ? '0 : ptr_t'(owner + 1'b1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      owner   <= '0;
      o_grant <= '0;
      o_enq   <= 1'b0;
      o_data  <= '0;
    end else begin
      o_enq <= xfer;
      if (xfer) o_data <= sel_data;
      unique case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            state   <= ST_STREAM;
            owner   <= pick_idx;
            o_grant <= pick_oh;
          end
        end
        ST_STREAM: begin
          if (last) begin
            state   <= ST_IDLE;
            o_grant <= '0;
`ifndef COUPLER_ARB_FIXED_PRIO_EN
            ptr     <= ptr_nxt;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coupler_arb.sv
// tb_coupler_arb: directed + random runs against a queue-based reference model.
// Model picks owners from FIFO occupancy and tracks run boundaries by element value.
module tb_coupler_arb;

  localparam int W = 128;
  localparam int N = 4;

  typedef logic [W-1:0] elem_t;

  logic           i_clk;
  logic           i_rst_n;
  logic [N*W-1:0] i_data;
  logic [N-1:0]   i_empty;
  logic [N-1:0]   o_deq;
  logic [W-1:0]   o_data;
  logic           o_enq;
  logic           i_full;
  logic [N-1:0]   o_grant;
  logic           o_busy;

  coupler_arb #(.P_WIDTH(W), .P_NUM(N)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (i_data),
    .i_empty (i_empty),
    .o_deq   (o_deq),
    .o_data  (o_data),
    .o_enq   (o_enq),
    .i_full  (i_full),
    .o_grant (o_grant),
    .o_busy  (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int       n_pass = 0;
  int       n_fail = 0;
  int       n_total = 0;

  elem_t    q[N][$];
  bit       m_busy;
  int       m_owner;
  int       m_ptr;
  bit       e_enq;
  elem_t    e_data;

  elem_t    out_log[$];
  int       grant_log[$];
  elem_t    exp_q[$];
  int       exp_g[$];
  logic [N-1:0] prev_grant;

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(int k);
    return N'(1) << k;
  endfunction

  function automatic elem_t rnd_elem();
    return {$urandom, $urandom, $urandom, $urandom} | elem_t'(1);
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_ptr   = 0;
    e_enq   = 0;
    e_data  = '0;
    prev_grant = '0;
  endtask

  task automatic step(bit full, logic [N-1:0] hold);
    logic [N-1:0] emp;
    logic [N-1:0] edeq;
    bit found;
    int k;
    @(negedge i_clk);
    chk("grant", W'(o_grant), m_busy ? W'(oh(m_owner)) : '0);
    chk("busy", W'(o_busy), W'(m_busy));
    chk("enq", W'(o_enq), W'(e_enq));
    chk("data", o_data, e_data);
    if (o_enq) out_log.push_back(o_data);
    if (o_grant != 0 && prev_grant == 0)
      for (int j = 0; j < N; j++) if (o_grant[j]) grant_log.push_back(j);
    prev_grant = o_grant;
    for (int j = 0; j < N; j++) begin
      emp[j] = (q[j].size() == 0) || hold[j];
      i_data[j*W +: W] = emp[j] ? {$urandom, $urandom, $urandom, $urandom}
                                : q[j][0];
    end
    i_empty = emp;
    i_full  = full;
    #1;
    edeq = (m_busy && !emp[m_owner] && !full) ? oh(m_owner) : '0;
    chk("deq", W'(o_deq), W'(edeq));
    e_enq = 0;
    if (!m_busy) begin
      found = 0;
      for (int i = 0; i < N; i++) begin
`ifdef COUPLER_ARB_FIXED_PRIO_EN
        k = i;
`else
        k = (m_ptr + i) % N;
`endif
        if (!found && !emp[k]) begin
          found   = 1;
          m_owner = k;
          m_busy  = 1;
        end
      end
    end else if (edeq != 0) begin
      e_enq  = 1;
      e_data = q[m_owner].pop_front();
      if (e_data == '0) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic run(int n);
    repeat (n) step(1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_deq", W'(o_deq), '0);
    chk("rst_enq", W'(o_enq), '0);
    chk("rst_data", o_data, '0);
    chk("rst_grant", W'(o_grant), '0);
    chk("rst_busy", W'(o_busy), '0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_empty = '1;
    i_full  = 1'b0;
    i_rst_n = 1'b1;
    for (int j = 0; j < N; j++) q[j].delete();
    model_reset();
  endtask

  task automatic push_run(int k, int len);
    for (int i = 0; i < len; i++) q[k].push_back(rnd_elem());
    q[k].push_back('0);
  endtask

  task automatic chk_out(string tag);
    chk({tag, "_len"}, W'(out_log.size()), W'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_log.size(); i++)
      chk(tag, out_log[i], exp_q[i]);
  endtask

  task automatic chk_grants(string tag);
    chk({tag, "_len"}, W'(grant_log.size()), W'(exp_g.size()));
    for (int i = 0; i < exp_g.size() && i < grant_log.size(); i++)
      chk(tag, W'(grant_log[i]), W'(exp_g[i]));
  endtask

  task automatic clear_logs();
    out_log.delete();
    grant_log.delete();
    exp_q.delete();
    exp_g.delete();
  endtask

  initial begin
    int total;
    bit saw9;
    i_rst_n = 1'b0;
    i_empty = '1;
    i_full  = 1'b0;
    i_data  = '0;
    model_reset();
    @(posedge i_clk);
    #1;
    chk("init_deq", W'(o_deq), '0);
    chk("init_enq", W'(o_enq), '0);
    chk("init_data", o_data, '0);
    chk("init_grant", W'(o_grant), '0);
    chk("init_busy", W'(o_busy), '0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Single requester 0: 5,7,0
    clear_logs();
    q[0].push_back(elem_t'(5));
    q[0].push_back(elem_t'(7));
    q[0].push_back(elem_t'(0));
    run(8);
    exp_q.push_back(elem_t'(5));
    exp_q.push_back(elem_t'(7));
    exp_q.push_back(elem_t'(0));
    exp_g.push_back(0);
    chk_out("single_out");
    chk_grants("single_grant");

    // Round-robin over all four, two rounds
    do_reset();
    for (int r = 0; r < 2; r++) begin
      clear_logs();
      for (int k = 0; k < N; k++) begin
        q[k].push_back(elem_t'(k + 1));
        q[k].push_back('0);
        exp_g.push_back(k);
      end
      run(16);
      chk_grants("rr_order");
    end

    // Stall by i_full mid-run on requester 1
    clear_logs();
    for (int i = 11; i <= 14; i++) q[1].push_back(elem_t'(i));
    q[1].push_back('0);
    run(3);
    repeat (4) step(1'b1, '0);
    run(8);
    for (int i = 11; i <= 14; i++) exp_q.push_back(elem_t'(i));
    exp_q.push_back('0);
    chk_out("stall_out");

    // Owner 0 goes empty mid-run while requester 2 waits
    clear_logs();
    for (int i = 21; i <= 23; i++) q[0].push_back(elem_t'(i));
    q[0].push_back('0);
    run(3);
    q[2].push_back(elem_t'(31));
    q[2].push_back('0);
    repeat (3) step(1'b0, 4'b0001);
    run(10);
    exp_g.push_back(0);
    exp_g.push_back(2);
    chk_grants("hold_owner");

    // Reset mid-run after element 9
    clear_logs();
    q[1].push_back(elem_t'(8));
    q[1].push_back(elem_t'(9));
    q[1].push_back(elem_t'(10));
    q[1].push_back('0);
    saw9 = 0;
    for (int i = 0; i < 20 && !saw9; i++) begin
      step(1'b0, '0);
      if (out_log.size() > 0 && out_log[out_log.size()-1] == elem_t'(9))
        saw9 = 1;
    end
    chk("saw_elem9", W'(saw9), W'(1));
    do_reset();
    clear_logs();
    q[0].push_back(elem_t'(41));
    q[0].push_back('0);
    q[3].push_back(elem_t'(43));
    q[3].push_back('0);
    run(10);
    exp_g.push_back(0);
    exp_g.push_back(3);
    chk_grants("post_rst");

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        int k;
        k = $urandom_range(0, N - 1);
        if (q[k].size() < 12) push_run(k, $urandom_range(1, 4));
      end
      step($urandom_range(0, 3) == 0, N'($urandom & $urandom));
    end
    run(120);
    total = 0;
    for (int k = 0; k < N; k++) total += q[k].size();
    chk("drain", W'(total), '0);

`ifdef COUPLER_ARB_FIXED_PRIO_EN
    clear_logs();
    push_run(3, 2);
    for (int c = 0; c < 60; c++) begin
      if (q[0].size() < 4) push_run(0, 1);
      step(1'b0, '0);
    end
    total = 0;
    foreach (grant_log[i]) if (grant_log[i] == 3) total++;
    chk("fixed_no3", W'(total), '0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
